// File: rtl/tt_um_ws2812b_transmitter_if.sv
// TinyQV byte-peripheral register bus shared by the WS2812B transmitter.
// The CPU side (master) drives address/write strobe/data; the peripheral
// (slave) returns combinational read data for the presented address.
interface tt_um_ws2812b_transmitter_if;
    logic [3:0] address;
    logic       data_write;
    logic [7:0] data_in;
    logic [7:0] data_out;

    modport master (
        output address,
        output data_write,
        output data_in,
        input  data_out
    );

    modport slave (
        input  address,
        input  data_write,
        input  data_in,
        output data_out
    );
endinterface

// File: rtl/tt_um_ws2812b_transmitter.sv
// WS2812B NRZ transmitter: shifts 24-bit GRB frames MSB first, optionally
// across a chain of LEDs reloaded from the live colour registers, and ends
// each transfer with a programmable low latch period.
module tt_um_ws2812b_transmitter (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [7:0]                         ui_in,
    output logic [7:0]                         uo_out,
    tt_um_ws2812b_transmitter_if.slave         bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        LATCH = 2'd3
    } state_t;

    localparam logic [3:0] ADDR_R      = 4'h0;
    localparam logic [3:0] ADDR_G      = 4'h1;
    localparam logic [3:0] ADDR_B      = 4'h2;
    localparam logic [3:0] ADDR_START  = 4'h3;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_T0H    = 4'h5;
    localparam logic [3:0] ADDR_T1H    = 4'h6;
    localparam logic [3:0] ADDR_PERIOD = 4'h7;
    localparam logic [3:0] ADDR_LAT_LO = 4'h8;
    localparam logic [3:0] ADDR_LAT_HI = 4'h9;
    localparam logic [3:0] ADDR_CTRL   = 4'hA;

    state_t      state;
    state_t      state_next;

    logic [7:0]  col_r;
    logic [7:0]  col_g;
    logic [7:0]  col_b;
    logic [7:0]  t0h;
    logic [7:0]  t1h;
    logic [7:0]  period;
    logic [15:0] latch_len;
    logic        invert;

    logic [23:0] shift_reg;
    logic [4:0]  bit_idx;
    logic [7:0]  led_cnt;
    logic [15:0] phase;
    logic        consumed;

    logic        busy;
    logic        start_wr;
    logic        colour_wr;
    logic        cfg_wr;
    logic [7:0]  th_raw;
    logic [7:0]  th;
    logic [7:0]  tl;
    logic        phase_clr;
    logic        do_start;
    logic        do_reload;
    logic        do_shift;
    logic        dout;

    // The input PMOD is not used by this peripheral.
    logic        unused_inputs;
    assign unused_inputs = &{1'b0, ui_in};

    assign busy      = (state != IDLE);
    assign start_wr  = bus.data_write && (bus.address == ADDR_START);
    assign colour_wr = bus.data_write && (bus.address <= ADDR_B);
    assign cfg_wr    = bus.data_write && !busy;

    // High time follows the bit under transmission; zero is stretched to one
    // cycle, and the low time never collapses below one cycle.
    assign th_raw = shift_reg[23] ? t1h : t0h;
    assign th     = (th_raw == 8'd0) ? 8'd1 : th_raw;
    assign tl     = (period > th) ? (period - th) : 8'd1;

    assign dout   = (state == HIGH);
    assign uo_out = {8{dout ^ invert}};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of all others.
            state <= state_next;
        end
    end

    // Next-state decode and datapath strobes for the bit/LED sequencer.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_next = state;
        phase_clr  = 1'b0;
        do_start   = 1'b0;
        do_reload  = 1'b0;
        do_shift   = 1'b0;
        case (state)
            IDLE: begin
                if (start_wr) begin
                    state_next = HIGH;
                    phase_clr  = 1'b1;
                    do_start   = 1'b1;
                end
            end
            HIGH: begin
                if (phase == ({8'd0, th} - 16'd1)) begin
                    state_next = LOW;
                    phase_clr  = 1'b1;
                end
            end
            LOW: begin
                if (phase == ({8'd0, tl} - 16'd1)) begin
                    phase_clr = 1'b1;
                    if (bit_idx != 5'd0) begin
                        do_shift   = 1'b1;
                        state_next = HIGH;
                    end else if (led_cnt != 8'd0) begin
                        do_reload  = 1'b1;
                        state_next = HIGH;
                    end else if (latch_len == 16'd0) begin
                        state_next = IDLE;
                    end else begin
                        state_next = LATCH;
                    end
                end
            end
            LATCH: begin
                if (phase == (latch_len - 16'd1)) begin
                    state_next = IDLE;
                    phase_clr  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shared phase counter, shift register, bit index and LED counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= 16'd0;
            shift_reg <= 24'd0;
            bit_idx   <= 5'd0;
            led_cnt   <= 8'd0;
        end else begin
            if (phase_clr || !busy) begin
                phase <= 16'd0;
            end else begin
                phase <= phase + 16'd1;
            end

            if (do_start || do_reload) begin
                // Loads see the pre-edge colour, so a same-edge colour write
                // is held over for the next LED.
                shift_reg <= {col_g, col_r, col_b};
                bit_idx   <= 5'd23;
            end else if (do_shift) begin
                shift_reg <= {shift_reg[22:0], 1'b0};
                bit_idx   <= bit_idx - 5'd1;
            end

            if (do_start) begin
                led_cnt <= bus.data_in;
            end else if (do_reload) begin
                led_cnt <= led_cnt - 8'd1;
            end
        end
    end

    // Consumed flag: a colour write clears it even on the edge of a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            consumed <= 1'b0;
        end else if (colour_wr) begin
            consumed <= 1'b0;
        end else if (do_start || do_reload) begin
            consumed <= 1'b1;
        end
    end

    // Register writes: colours always accepted, timing/control only when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r     <= 8'h00;
            col_g     <= 8'h00;
            col_b     <= 8'h00;
            t0h       <= 8'd26;
            t1h       <= 8'd51;
            period    <= 8'd80;
            latch_len <= 16'h0F00;
            invert    <= 1'b0;
        end else if (bus.data_write) begin
            case (bus.address)
                ADDR_R: col_r <= bus.data_in;
                ADDR_G: col_g <= bus.data_in;
                ADDR_B: col_b <= bus.data_in;
                ADDR_T0H: if (cfg_wr) t0h <= bus.data_in;
                ADDR_T1H: if (cfg_wr) t1h <= bus.data_in;
                ADDR_PERIOD: if (cfg_wr) period <= bus.data_in;
                ADDR_LAT_LO: if (cfg_wr) latch_len[7:0] <= bus.data_in;
                ADDR_LAT_HI: if (cfg_wr) latch_len[15:8] <= bus.data_in;
                ADDR_CTRL: if (cfg_wr) invert <= bus.data_in[0];
                default: ;
            endcase
        end
    end

    // Combinational read mux; unmapped addresses return zero.
    always_comb begin
        bus.data_out = 8'h00;
        case (bus.address)
            ADDR_R:      bus.data_out = col_r;
            ADDR_G:      bus.data_out = col_g;
            ADDR_B:      bus.data_out = col_b;
            ADDR_START:  bus.data_out = led_cnt;
            ADDR_STATUS: bus.data_out = {6'd0, consumed, busy};
            ADDR_T0H:    bus.data_out = t0h;
            ADDR_T1H:    bus.data_out = t1h;
            ADDR_PERIOD: bus.data_out = period;
            ADDR_LAT_LO: bus.data_out = latch_len[7:0];
            ADDR_LAT_HI: bus.data_out = latch_len[15:8];
            ADDR_CTRL:   bus.data_out = {7'd0, invert};
            default:     bus.data_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_tt_um_ws2812b_transmitter.sv
// Self-checking bench for the WS2812B transmitter: the stimulus thread
// queues the expected pulse train computed from the bit-timing rules, and a
// line monitor measures each pulse on uo_out and compares it against the queue.
`timescale 1ns/1ps
module tb_tt_um_ws2812b_transmitter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uo_out;

    tt_um_ws2812b_transmitter_if bus ();

    tt_um_ws2812b_transmitter dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int hi;
        int lo;
        bit last;
    } pulse_t;

    pulse_t exp_q[$];

    int m_t0h, m_t1h, m_period, m_latch;
    bit inv = 1'b0;
    bit mon_en = 1'b0;

    task automatic model_defaults();
        m_t0h = 26; m_t1h = 51; m_period = 80; m_latch = 3840;
    endtask

    function automatic int high_of(bit b);
        int t;
        t = b ? m_t1h : m_t0h;
        return (t == 0) ? 1 : t;
    endfunction

    function automatic int low_of(bit b);
        int h;
        h = high_of(b);
        return (m_period > h) ? (m_period - h) : 1;
    endfunction

    // Queues the 24 pulses of one LED and returns their total duration.
    function automatic int queue_led(input logic [23:0] grb, input bit last_led);
        int total;
        pulse_t p;
        total = 0;
        for (int i = 23; i >= 0; i--) begin
            p.hi = high_of(grb[i]);
            p.lo = low_of(grb[i]);
            p.last = last_led && (i == 0);
            exp_q.push_back(p);
            total += p.hi + p.lo;
        end
        return total;
    endfunction

    // ---------------- line monitor ----------------
    int     mon_mode = 0;
    int     hi_cnt = 0;
    int     lo_cnt = 0;
    pulse_t cur;
    bit     lvl;

    always @(negedge clk) begin
        if (!rst_n || !mon_en) begin
            mon_mode = 0;
            hi_cnt = 0;
            lo_cnt = 0;
        end else begin
            lvl = uo_out[0] ^ inv;
            case (mon_mode)
                0: if (lvl) begin
                    check("uo_replicated", uo_out, {8{uo_out[0]}});
                    hi_cnt = 1;
                    mon_mode = 1;
                end
                1: if (lvl) begin
                    hi_cnt++;
                end else begin
                    check("pulse_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        cur = exp_q.pop_front();
                        check("bit_high", hi_cnt, cur.hi);
                        if (cur.last) begin
                            mon_mode = 0;
                        end else begin
                            lo_cnt = 1;
                            mon_mode = 2;
                        end
                    end else begin
                        mon_mode = 0;
                    end
                end
                default: if (!lvl) begin
                    lo_cnt++;
                end else begin
                    check("bit_low", lo_cnt, cur.lo);
                    check("uo_replicated", uo_out, {8{uo_out[0]}});
                    hi_cnt = 1;
                    mon_mode = 1;
                end
            endcase
        end
    end

    // ---------------- bus helpers ----------------
    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.address = a;
        bus.data_in = d;
        bus.data_write = 1'b1;
        @(negedge clk);
        bus.data_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        bus.data_write = 1'b0;
        bus.address = a;
        #1;
        d = bus.data_out;
    endtask

    task automatic rd_check(input logic [3:0] a, input logic [7:0] exp, input string name);
        logic [7:0] d;
        rd(a, d);
        check(name, d, exp);
    endtask

    task automatic cfg(input logic [3:0] a, input logic [7:0] d);
        wr(a, d);
        case (a)
            4'h5: m_t0h = d;
            4'h6: m_t1h = d;
            4'h7: m_period = d;
            4'h8: m_latch = (m_latch & 32'hFF00) | d;
            4'h9: m_latch = (m_latch & 32'h00FF) | (int'(d) << 8);
            default: ;
        endcase
    endtask

    task automatic set_latch(input int v);
        cfg(4'h8, v[7:0]);
        cfg(4'h9, v[15:8]);
    endtask

    task automatic set_colour(input logic [23:0] grb);
        wr(4'h1, grb[23:16]);
        wr(4'h0, grb[15:8]);
        wr(4'h2, grb[7:0]);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic start(input logic [7:0] n, output int st);
        wr(4'h3, n);
        st = cyc;
    endtask

    task automatic wait_idle(input int st, input int exp_len, input string name);
        logic [7:0] s;
        forever begin
            rd(4'h4, s);
            if (!s[0]) break;
            if (cyc - st > exp_len + 200) break;
            @(negedge clk);
        end
        check(name, cyc - st, exp_len);
    endtask

    task automatic wait_consumed(input int bound, input string name);
        logic [7:0] s;
        int n;
        n = 0;
        s = 8'h00;
        while (n < bound) begin
            rd(4'h4, s);
            if (s[1]) break;
            @(negedge clk);
            n++;
        end
        check(name, s[1], 1'b1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0]  d;
        logic [23:0] c0, c1;
        int st, total, cnt;
        logic [7:0] def_regs [16];

        bus.address = 4'h0;
        bus.data_in = 8'h00;
        bus.data_write = 1'b0;
        model_defaults();
        def_regs = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'd26, 8'd51, 8'd80,
                     8'h00, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        // Reset defaults.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        check("reset_uo_out", uo_out, 8'h00);
        for (int a = 0; a < 16; a++) rd_check(4'(a), def_regs[a], "reset_reg");

        // Single LED with the canonical colour and default timing.
        set_colour(24'h800001);
        rd_check(4'h1, 8'h80, "colour_g_rb");
        rd_check(4'h2, 8'h01, "colour_b_rb");
        void'(queue_led(24'h800001, 1'b1));
        start(8'h00, st);
        rd_check(4'h4, 8'h03, "status_busy_consumed");
        check("uo_high_after_start", uo_out, 8'hFF);
        wait_idle(st, 5760, "single_led_len");

        // Streaming three LEDs, new colour after each consumed rise.
        c0 = $urandom;
        set_colour(c0);
        total = queue_led(c0, 1'b0);
        start(8'h02, st);
        rd_check(4'h3, 8'd2, "remaining_0");
        for (int k = 1; k <= 2; k++) begin
            c1 = $urandom;
            set_colour(c1);
            rd_check(4'h4, 8'h01, "consumed_cleared");
            total += queue_led(c1, k == 2);
            wait_consumed(3000, "consumed_rise");
            rd_check(4'h3, 8'(2 - k), "remaining_k");
        end
        wait_idle(st, total + m_latch, "stream_len");

        // Start and config writes while busy are ignored.
        c0 = $urandom;
        set_colour(c0);
        void'(queue_led(c0, 1'b1));
        start(8'h00, st);
        wait_cyc(st + 100);
        wr(4'h3, 8'h05);
        wr(4'h7, 8'd20);
        rd_check(4'h7, 8'd80, "period_locked");
        rd_check(4'h3, 8'd0, "no_restart_cnt");
        wait_idle(st, 5760, "busy_start_len");

        // Colour write on the same edge as the second LED's load.
        c0 = $urandom;
        set_colour(c0);
        total = queue_led(c0, 1'b0);
        total += queue_led(c0, 1'b1);
        start(8'h01, st);
        wait_cyc(st + 1918);
        wr(4'h1, ~c0[23:16]);
        rd_check(4'h4, 8'h01, "clear_wins");
        wait_idle(st, total + m_latch, "coincide_len");

        // Randomized timing and colours.
        for (int k = 0; k < 4; k++) begin
            cfg(4'h5, 8'($urandom_range(0, 12)));
            cfg(4'h6, 8'($urandom_range(13, 25)));
            cfg(4'h7, 8'($urandom_range(20, 40)));
            set_latch($urandom_range(0, 300));
            c0 = $urandom;
            cnt = $urandom_range(0, 2);
            set_colour(c0);
            rd_check(4'h0, c0[15:8], "colour_r_rb");
            total = 0;
            for (int j = 0; j <= cnt; j++) total += queue_led(c0, j == cnt);
            start(8'(cnt), st);
            wait_idle(st, total + m_latch, "rand_len");
        end

        // Boundary timing: T1H beyond PERIOD, T0H zero, LATCH zero.
        cfg(4'h5, 8'd26); cfg(4'h6, 8'd90); cfg(4'h7, 8'd80); set_latch(100);
        c0 = $urandom;
        set_colour(c0);
        total = queue_led(c0, 1'b1);
        start(8'h00, st);
        wait_idle(st, total + 100, "t1h_over_len");

        cfg(4'h5, 8'd0); cfg(4'h6, 8'd51);
        c0 = $urandom & 24'h0F0F0F;
        set_colour(c0);
        total = queue_led(c0, 1'b1);
        start(8'h00, st);
        wait_idle(st, total + 100, "t0h_zero_len");

        cfg(4'h5, 8'd26); set_latch(0);
        c0 = $urandom;
        set_colour(c0);
        void'(queue_led(c0, 1'b1));
        start(8'h00, st);
        wait_idle(st, 1920, "latch_zero_len");

        // Inverted output, then asynchronous reset mid-bit.
        cfg(4'h5, 8'd8); cfg(4'h6, 8'd16); cfg(4'h7, 8'd30); set_latch(50);
        mon_en = 1'b0;
        wr(4'hA, 8'h01);
        inv = 1'b1;
        mon_en = 1'b1;
        check("idle_inverted", uo_out, 8'hFF);
        c0 = $urandom;
        set_colour(c0);
        total = queue_led(c0, 1'b1);
        start(8'h00, st);
        check("inverted_pulse", uo_out, 8'h00);
        wait_idle(st, total + 50, "invert_len");

        c0 = $urandom;
        set_colour(c0);
        void'(queue_led(c0, 1'b0));
        start(8'h03, st);
        wait_cyc(st + 3);
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_reset_uo", uo_out, 8'h00);
        rd_check(4'h4, 8'h00, "async_reset_status");
        rd_check(4'h7, 8'd80, "async_reset_period");
        rd_check(4'hA, 8'h00, "async_reset_ctrl");
        exp_q.delete();
        model_defaults();
        inv = 1'b0;
        @(negedge clk);
        rd_check(4'h0, 8'h00, "async_reset_colour");
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_idle", uo_out, 8'h00);

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_um_ws2812b_transmitter.md
# tt_um_ws2812b_transmitter

TinyQV byte peripheral that generates a WS2812B single-wire NRZ stream from CPU-written colour bytes. It shifts out 24-bit GRB frames MSB first, optionally repeating across a chain of LEDs while software streams the next colour. It finishes each transfer with a programmable low latch period. It is the transmit-side companion of the WS2812B receive peripheral and shares its register style and its 64 MHz timing defaults.

## Interface
Parameters: none. Timing is fully register-programmable.

- clk  input  1  TinyQV project clock, nominally 64 MHz
- rst_n  input  1  reset; asynchronous, active-low
- ui_in  input  8  input PMOD; unused
- uo_out  output  8  serial output (dout XOR invert) replicated on all 8 bits
- address  input  4  register address
- data_write  input  1  write strobe; data_in valid
- data_in  input  8  write data
- data_out  output  8  combinational read data for address

## Operation
Register map (R = read, W = write):
- 0x0 R, 0x1 G, 0x2 B: colour bytes, R/W. Reset value 0x00.
- 0x3 W: start. data_in = LED count − 1 (0..255). Ignored while busy. R returns remaining LED count (LEDs still to load after the current one).
- 0x4 R: status. bit0 = busy, bit1 = consumed, other bits 0.
- 0x5 T0H, 0x6 T1H, 0x7 PERIOD: bit timing in cycles, R/W. Defaults 26, 51, 80.
- 0x8/0x9 LATCH[7:0]/[15:8]: latch length in cycles, R/W. Default 3840 (0x0F00).
- 0xA CTRL: bit0 = invert output, R/W. Default 0.
- Unmapped reads return 0x00. Writes to 0x5–0xA while busy are ignored.

FSM states:
- IDLE: dout = 0. On start, load shift register {G,R,B} from the live registers, set consumed, set the LED counter to data_in and the bit index to 23, then go to HIGH.
- HIGH: dout = 1 for Th cycles. Th = T1H if the shift MSB is 1, else T0H. A value of 0 is treated as 1. Then go to LOW.
- LOW: dout = 0 for max(PERIOD − Th, 1) cycles.
  - If bit index > 0: shift left, decrement the index, go to HIGH.
  - Else, if the LED counter > 0: decrement it, reload the shift register from the live R/G/B, set consumed, index = 23, go to HIGH.
  - Else: go to LATCH, or to IDLE if LATCH = 0.
- LATCH: dout = 0 for LATCH cycles, then IDLE.

Consumed flag:
- Cleared by any write to 0x0–0x2.
- If that write coincides with a shift-register load, the clear wins. The load takes the old value and the new value waits for the next LED.

Other rules:
- busy = (state ≠ IDLE).
- Counters: one 16-bit phase counter shared by HIGH, LOW and LATCH; 5-bit bit index; 8-bit LED counter.

## Timing
- Reset (async): state IDLE, dout 0, uo_out 0x00, all registers at their defaults, status 0x00. Reset takes effect immediately, mid-frame included.
- Start write sampled at edge N:
  - busy reads 1 after edge N.
  - uo_out goes high after edge N (0 cycles of added latency).
- Each bit occupies exactly Th + max(PERIOD − Th, 1) cycles. Bits are back to back and there is no gap between LEDs.
- A frame with defaults lasts 24·(count+1)·80 + 3840 cycles from edge N to busy = 0.
- For continuous streaming, software writes the next colour within 24·PERIOD cycles of consumed rising.
- data_out is combinational from address and current state. There is no read latency.

## Test plan
- **Reset defaults:** reset, then read all registers.
  - 0x5 = 26, 0x6 = 51, 0x7 = 80, 0x8 = 0x00, 0x9 = 0x0F, 0x4 = 0x00; uo_out = 0x00.
- **Single LED:** write G = 0x80, R = 0x00, B = 0x01, start with 0x00.
  - Bit 0: 51 cycles high, 29 low.
  - Bits 1–22: 26 high, 54 low each.
  - Bit 23: 51 high, 29 low.
  - Then 3840 cycles low; busy falls exactly 5760 cycles after start.
- **Streaming, three LEDs:** start with 0x02 and rewrite the colour after each consumed rise.
  - 72 bits are sent, each LED carrying the colour written for it.
  - 0x3 reads 2, 1, 0 across the frame.
- **Boundary timing:**
  - T1H = 90 with PERIOD = 80: 1-bits are 90 high, 1 low.
  - T0H = 0: 0-bits are 1 high.
  - LATCH = 0: busy clears the cycle after the last LOW phase.
- **Ignored and simultaneous writes:**
  - Start while busy: no restart; frame length unchanged.
  - Write to 0x7 while busy: ignored; reads back its old value.
  - Colour write on the same edge as a load: consumed = 0, and the old colour is transmitted.
- **Async reset and invert:**
  - rst_n low mid-bit: uo_out = 0x00 before the next edge, busy = 0, defaults restored.
  - With CTRL = 1: idle uo_out = 0xFF and pulses are inverted.
